// File: rtl/shreg_pkg.sv
// shreg_pkg: op codes and FSM state encoding shared by param_shift_reg and shreg_step
package shreg_pkg;
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ROL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/shreg_step.sv
// shreg_step: one-position shift/rotate of q for op, with si as fill bit
// ports: q current value, op operation, si serial fill, q_next stepped value, out_bit bit leaving q
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             si,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);
  always_comb begin
    q_next = q;
    out_bit = 1'b0;
    case (op)
      OP_ROL: begin q_next = {q[WIDTH-2:0], q[WIDTH-1]}; out_bit = q[WIDTH-1]; end
      OP_SHL: begin q_next = {q[WIDTH-2:0], si}; out_bit = q[WIDTH-1]; end
      OP_ROR: begin q_next = {q[0], q[WIDTH-1:1]}; out_bit = q[0]; end
      OP_SHR: begin q_next = {si, q[WIDTH-1:1]}; out_bit = q[0]; end
      OP_ASR: begin q_next = {q[WIDTH-1], q[WIDTH-1:1]}; out_bit = q[0]; end
      default: q_next = q;
    endcase
  end
endmodule

// File: rtl/param_shift_reg.sv
// param_shift_reg: universal WIDTH-bit shift register with start/busy/done handshake
// ports: clk, reset (async high), start/op/amount/D request, SI serial fill,
//        Q contents, SO last bit out, busy (RUN), done (one-cycle pulse)
// SHREG_BARREL_EN: when defined, shifts/rotates finish in one edge through a barrel network
module param_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] op_r, op_n;
  logic [WIDTH-1:0] q_r, q_n, step_q;
  logic so_r, so_n, step_out, is_shift;
  assign is_shift = !(op inside {OP_HOLD, OP_LOAD, OP_CLR});
  shreg_step #(.WIDTH(WIDTH)) u_step (
    .q      (q_r),
    .op     (op_r),
    .si     (SI),
    .q_next (step_q),
    .out_bit(step_out)
  );
`ifdef SHREG_BARREL_EN
  logic [WIDTH-1:0] bar_q, fill, sh;
  logic bar_so;
  int a, r;
  // sh holds the last bit out at position 0; for counts beyond WIDTH it is the fill value
  always_comb begin
    a = {{(32-CNT_W){1'b0}}, amount};
    r = a % WIDTH;
    fill = {WIDTH{SI}};
    bar_q = q_r;
    sh = '0;
    case (op)
      OP_ROL: begin bar_q = (q_r << r) | (q_r >> (WIDTH - r)); sh = q_r >> ((WIDTH - r) % WIDTH); end
      OP_ROR: begin bar_q = (q_r >> r) | (q_r << (WIDTH - r)); sh = q_r >> ((a - 1) % WIDTH); end
      OP_SHL: begin
        bar_q = (a >= WIDTH) ? fill : (q_r << a) | (fill >> (WIDTH - a));
        sh = (a <= WIDTH) ? q_r >> (WIDTH - a) : fill;
      end
      OP_SHR: begin
        bar_q = (a >= WIDTH) ? fill : (q_r >> a) | (fill << (WIDTH - a));
        sh = (a <= WIDTH) ? q_r >> (a - 1) : fill;
      end
      OP_ASR: begin
        bar_q = $signed(q_r) >>> a;
        sh = (a <= WIDTH) ? q_r >> (a - 1) : {WIDTH{q_r[WIDTH-1]}};
      end
      default: bar_q = q_r;
    endcase
    bar_so = sh[0];
  end
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    op_n = op_r;
    q_n = q_r;
    so_n = so_r;
    case (state)
      ST_IDLE: if (start) begin
        state_n = ST_DONE;
        if (op == OP_LOAD) q_n = D;
        else if (op == OP_CLR) q_n = '0;
`ifdef SHREG_BARREL_EN
        else if (is_shift && amount != '0) begin q_n = bar_q; so_n = bar_so; end
`else
        else if (is_shift && amount != '0) begin state_n = ST_RUN; op_n = op; cnt_n = amount; end
`endif
      end
      ST_RUN: begin
        q_n = step_q;
        so_n = step_out;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      op_r <= OP_HOLD;
      q_r <= '0;
      so_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op_r <= op_n;
      q_r <= q_n;
      so_r <= so_n;
    end
  end
  assign Q = q_r;
  assign SO = so_r;
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised universal shift register: WIDTH-bit storage with an 8-operation set. Operations are load, clear, rotate and logical/arithmetic shift in either direction.
- Multi-position shifts run under a start/busy/done handshake. The iterative build applies one bit-step per clock.
- Generalised successor of the 4-bit, 4-mode universal register. Used as a datapath shifter and serial/parallel converter in lab designs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the amount input and internal step counter. Must satisfy 2^CNT_W-1 >= WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only in IDLE
- op  input  3  operation code, sampled with start
- amount  input  CNT_W  step count for shift/rotate ops, sampled with start
- D  input  WIDTH  parallel load data, sampled with start
- SI  input  1  serial fill bit, sampled live on every step edge
- Q  output  WIDTH  register contents
- SO  output  1  last bit shifted/rotated out (registered)
- busy  output  1  high while in RUN
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset (async, any state): Q=0, SO=0, busy=0, done=0, state=IDLE, counter=0.
- Op codes:
  - 000 HOLD.
  - 001 LOAD: Q<=D.
  - 010 ROL: Q[i]<=Q[i-1], Q[0]<=Q[W-1].
  - 011 SHR: Q[i]<=Q[i+1], Q[W-1]<=SI.
  - 100 ROR: Q[i]<=Q[i+1], Q[W-1]<=Q[0].
  - 101 SHL: Q[i]<=Q[i-1], Q[0]<=SI.
  - 110 ASR: Q[i]<=Q[i+1], Q[W-1] kept.
  - 111 CLR: Q<=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=0: no change.
  - start=1 with HOLD/LOAD/CLR: Q updated at that edge (E0), go to DONE.
  - start=1 with shift/rotate op and amount=0: Q and SO unchanged, go to DONE.
  - start=1 with shift/rotate op and amount>0: latch op, counter<=amount, go to RUN.
- RUN:
  - Each edge applies one step and decrements the counter.
  - SO<=bit leaving the register on that step: Q[W-1] for ROL/SHL, Q[0] for ROR/SHR/ASR.
  - On the step where counter==1, go to DONE.
  - busy=1 for exactly `amount` cycles.
- DONE: done=1 for one cycle, then IDLE. Next start is accepted in the cycle after done (the IDLE cycle).
- Latency: done asserts in the cycle after edge E0+amount. Single-cycle ops have done in the cycle after E0.
- start while busy or in DONE: ignored, no queuing. op, amount and D changes during RUN have no effect. SI is not latched; each step uses the SI present at that edge.
- amount > WIDTH is legal:
  - Rotates wrap modulo WIDTH naturally.
  - SHL/SHR fully flush to SI.
  - ASR saturates to all-sign.
- SO is unchanged by LOAD, CLR and HOLD.

Optional Feature:
- Macro: SHREG_BARREL_EN.
- When defined:
  - Shift/rotate ops complete in a single edge E0 via a barrel network. Effective count is amount (rotates modulo WIDTH).
  - All vacated positions take SI (SHL/SHR) or the sign bit (ASR).
  - SO = last bit out.
  - busy never asserts; done pulses in the cycle after E0, as for LOAD.
- When undefined: iterative behaviour above.
- Final Q and SO are identical in both builds, provided SI is constant during the operation.

Decomposition:
- Package shreg_pkg:
  - op-code localparams (OP_HOLD..OP_CLR).
  - state encoding (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module shreg_step: combinational single-step next-value function (Q, op, SI -> next Q, out bit), parametrised by WIDTH. The RUN path instantiates it once.

Test Plan (WIDTH=8):
- Q=0x81, ROL amount=1 -> Q=0x03, SO=1, busy 1 cycle, done the following cycle.
- Q=0xB4, SHR amount=3, SI=1 -> Q=0xF6, SO=1, busy 3 cycles.
- Q=0x90, ASR amount=2 -> Q=0xE4, SO=0. Then ROR 0x01 amount=9 -> Q=0x80, SO=1.
- LOAD D=0x5A, then SHL amount=0 -> Q stays 0x5A, done 1 cycle after start, busy never high. Then CLR -> Q=0x00.
- Start SHL amount=5 on 0xFF, pulse start again and change op mid-RUN -> ignored; Q=0xE0 with SI=0.
- Assert reset asynchronously mid-RUN (between edges) -> Q=0, busy=0, done=0 immediately. Next start behaves normally.
